// File: rtl/mc_core_top.sv
// Multicycle 9-bit-ISA core: FETCH/EXEC per instruction, req/ack data memory
// stage for LD/ST, start/done run control and a saturating busy-cycle counter.
module mc_core_top #(
  parameter int unsigned D  = 12,
  parameter int unsigned DW = 8,
  parameter int unsigned RA = 3,
  localparam int unsigned IW = 3 + 2 * RA
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [D-1:0]  imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic [31:0]   cycles
);
  localparam int unsigned NREG = 1 << RA;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_XOR = 3'b011,
    OP_LDI = 3'b100, OP_LD  = 3'b101, OP_ST  = 3'b110, OP_BR  = 3'b111
  } op_t;

  state_t        state, state_nxt;
  logic [D-1:0]  pc;
  logic [IW-1:0] ir;
  logic [DW-1:0] regs [NREG];
  logic          z, n;

  op_t           op;
  logic [RA-1:0] rd, rs;
  logic          is_halt, is_mem, br_taken;
  logic [DW-1:0] a, b, alu_res, imm_ext;
  logic [D-1:0]  pc_inc, br_off;

  assign op       = op_t'(ir[IW-1 -: 3]);
  assign rd       = ir[2*RA-1 -: RA];
  assign rs       = ir[RA-1:0];
  assign is_halt  = &ir;
  assign is_mem   = (op == OP_LD) || (op == OP_ST);
  assign a        = regs[rd];
  assign b        = regs[rs];
  assign imm_ext  = {{(DW-RA){1'b0}}, rs};
  assign pc_inc   = pc + D'(1);
  assign br_off   = {{(D-RA){rs[RA-1]}}, rs};
  assign br_taken = rd[0] ? n : z;
  assign imem_addr = pc;

  always_comb begin
    alu_res = a + b;
    case (op)
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_XOR:  alu_res = a ^ b;
      default: alu_res = a + b;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (is_halt)     state_nxt = S_DONE;
        else if (is_mem) state_nxt = S_MEM;
        else             state_nxt = S_FETCH;
      end
      S_MEM: begin
        busy = 1'b1;
        if (dmem_ack) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= '0;
      ir         <= '0;
      regs       <= '{default: '0};
      z          <= 1'b0;
      n          <= 1'b0;
      cycles     <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      if (busy && (cycles != '1)) cycles <= cycles + 32'd1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc     <= '0;
            cycles <= '0;
          end
        end
        S_FETCH: ir <= imem_data;
        S_EXEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
              regs[rd] <= alu_res;
              z        <= (alu_res == '0);
              n        <= alu_res[DW-1];
              pc       <= pc_inc;
            end
            OP_LDI: begin
              regs[rd] <= imm_ext;
              pc       <= pc_inc;
            end
            OP_LD, OP_ST: begin
              dmem_req   <= 1'b1;
              dmem_we    <= (op == OP_ST);
              dmem_addr  <= b;
              dmem_wdata <= a;
            end
            default: if (!is_halt) pc <= br_taken ? pc + br_off : pc_inc;
          endcase
        end
        S_MEM: begin
          // pc advances only when the access completes, so a LD/ST retires in the ack cycle
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) regs[rd] <= dmem_rdata;
            pc <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_core_top.sv
// Randomized self-checking bench for mc_core_top against an instruction-level
// reference model with a variable-latency data memory responder.
module tb_mc_core_top;
  localparam int unsigned D = 12, DW = 8, RA = 3, IW = 9;

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic          busy, done, dmem_req, dmem_we;
  logic [D-1:0]  imem_addr;
  logic [IW-1:0] imem_data;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_ack = 1'b0;
  logic [31:0]   cycles;

  logic [8:0] rom [4096];
  logic [7:0] dmem [256];
  logic [7:0] mmem [256];
  logic [7:0] mregs [8];
  logic       mz, mn;
  logic [8:0] prog [$];

  int unsigned n_checks = 0, n_errors = 0;
  int unsigned ack_lat = 1, req_cycles = 0, req_hi_cnt = 0, st_cnt = 0;
  bit          stray_en = 1'b0, stray_all = 1'b0;
  logic        lat_we;
  logic [7:0]  lat_addr, lat_wdata;

  always #5 clk = ~clk;
  assign imem_data = rom[imem_addr];

  mc_core_top #(.D(D), .DW(DW), .RA(RA)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .cycles(cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Data memory: ack after ack_lat request cycles; optional stray acks while idle
  always @(negedge clk) begin
    dmem_ack = 1'b0;
    check_eq("busy_done_excl", 32'(busy & done), 32'd0);
    if (reset && dmem_req) begin
      req_cycles++;
      req_hi_cnt++;
      if (req_cycles == 1) begin
        lat_we = dmem_we; lat_addr = dmem_addr; lat_wdata = dmem_wdata;
      end else begin
        check_eq("req_we_stable",    32'(dmem_we),    32'(lat_we));
        check_eq("req_addr_stable",  32'(dmem_addr),  32'(lat_addr));
        check_eq("req_wdata_stable", 32'(dmem_wdata), 32'(lat_wdata));
      end
      if (req_cycles == ack_lat) begin
        dmem_ack = 1'b1;
        if (dmem_we) begin
          dmem[dmem_addr] = dmem_wdata;
          st_cnt++;
        end else begin
          dmem_rdata = dmem[dmem_addr];
        end
      end
    end else begin
      req_cycles = 0;
      if (stray_all || (stray_en && $urandom_range(0, 3) == 0)) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 8'($urandom);
      end
    end
  end

  function automatic logic [8:0] enc(input int unsigned op, input int unsigned rd, input int unsigned rs);
    return {3'(op), 3'(rd), 3'(rs)};
  endfunction

  task automatic emit(input int unsigned op, input int unsigned rd, input int unsigned rs);
    prog.push_back(enc(op, rd, rs));
  endtask

  // Dump r0..r6 to mem[0..6], Z to mem[7], N to mem[14]
  task automatic emit_epilogue();
    for (int unsigned i = 0; i < 7; i++) begin
      emit(4, 7, i);
      emit(6, i, 7);
    end
    emit(4, 6, 1); emit(7, 0, 2); emit(4, 6, 0);
    emit(4, 5, 1); emit(7, 1, 2); emit(4, 5, 0);
    emit(4, 7, 7); emit(6, 6, 7); emit(0, 7, 7); emit(6, 5, 7);
    emit(7, 7, 7);
  endtask

  task automatic load_prog();
    for (int unsigned i = 0; i < 4096; i++) rom[i] = 9'h1FF;
    for (int unsigned i = 0; i < prog.size(); i++) rom[i] = prog[i];
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < 8; i++) mregs[i] = 8'h00;
    mz = 1'b0;
    mn = 1'b0;
  endtask

  // Instruction-level execution; returns expected busy-cycle count (0 = runaway)
  function automatic int unsigned model_run(input int unsigned lat);
    int unsigned pc, cyc, op, rd, rs, a, b, r;
    logic [8:0]  ins;
    bit          taken;
    pc = 0;
    cyc = 0;
    for (int unsigned step = 0; step < 5000; step++) begin
      ins = rom[pc];
      op = ins[8:6]; rd = ins[5:3]; rs = ins[2:0];
      cyc += 2;
      if (ins == 9'h1FF) return cyc;
      a = mregs[rd];
      b = mregs[rs];
      case (op)
        0, 1, 2, 3: begin
          case (op)
            0:       r = (a + b) % 256;
            1:       r = (a + 256 - b) % 256;
            2:       r = a & b;
            default: r = a ^ b;
          endcase
          mregs[rd] = 8'(r);
          mz = (r == 0);
          mn = (r >= 128);
          pc = (pc + 1) % 4096;
        end
        4: begin mregs[rd] = 8'(rs); pc = (pc + 1) % 4096; end
        5: begin mregs[rd] = mmem[mregs[rs]]; cyc += lat; pc = (pc + 1) % 4096; end
        6: begin mmem[mregs[rs]] = mregs[rd]; cyc += lat; pc = (pc + 1) % 4096; end
        default: begin
          taken = (rd % 2 == 0) ? mz : mn;
          if (taken) pc = (pc + 4096 + rs - ((rs >= 4) ? 8 : 0)) % 4096;
          else       pc = (pc + 1) % 4096;
        end
      endcase
    end
    return 0;
  endfunction

  task automatic run_and_check(input string tag, input int unsigned lat, input bit poke);
    int unsigned exp_cyc, waited;
    exp_cyc = model_run(lat);
    ack_lat = lat;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check_eq({tag, "_done_after_start"}, 32'(done), 32'd0);
    waited = 0;
    while (!done && waited < 4000) begin
      start = poke && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    check_eq({tag, "_done_timeout"}, 32'(done), 32'd1);
    check_eq({tag, "_cycles"}, cycles, exp_cyc);
    repeat (3) @(negedge clk);
    check_eq({tag, "_cycles_held"}, cycles, exp_cyc);
    check_eq({tag, "_done_sticky"}, 32'(done), 32'd1);
    check_eq({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic compare_mem(input string tag);
    for (int unsigned i = 0; i < 256; i++)
      check_eq($sformatf("%s_mem%0d", tag, i), 32'(dmem[i]), 32'(mmem[i]));
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq({tag, "_req"},   32'(dmem_req),  32'd0);
    check_eq({tag, "_pc"},    32'(imem_addr), 32'd0);
    check_eq({tag, "_busy"},  32'(busy),      32'd0);
    check_eq({tag, "_done"},  32'(done),      32'd0);
    check_eq({tag, "_cycles"}, cycles,        32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned st0, rq0, waited, len, sel;
    logic [7:0]  v, keep3;

    for (int unsigned i = 0; i < 256; i++) begin
      v = 8'($urandom);
      dmem[i] = v;
      mmem[i] = v;
    end
    model_reset();
    prog.delete();
    load_prog();

    repeat (2) @(negedge clk);
    check_eq("rst_busy",   32'(busy),      32'd0);
    check_eq("rst_done",   32'(done),      32'd0);
    check_eq("rst_cycles", cycles,         32'd0);
    check_eq("rst_req",    32'(dmem_req),  32'd0);
    check_eq("rst_we",     32'(dmem_we),   32'd0);
    check_eq("rst_pc",     32'(imem_addr), 32'd0);
    reset = 1'b1;

    // ALU sequence
    prog.delete();
    emit(4, 1, 3); emit(4, 2, 5); emit(0, 1, 2); emit(7, 7, 7);
    load_prog();
    run_and_check("t1", 1, 1'b0);
    check_eq("t1_cycles8", cycles, 32'd8);

    // Registers/flags persist into the next run
    prog.delete();
    emit_epilogue();
    load_prog();
    run_and_check("t1b", 2, 1'b0);
    check_eq("t1b_r1", 32'(dmem[1]),  32'd8);
    check_eq("t1b_r2", 32'(dmem[2]),  32'd5);
    check_eq("t1b_z",  32'(dmem[7]),  32'd0);
    check_eq("t1b_n",  32'(dmem[14]), 32'd0);
    compare_mem("t1b");

    // Store with 4-cycle ack latency
    prog.delete();
    emit(6, 1, 2); emit(7, 7, 7);
    load_prog();
    st0 = st_cnt;
    rq0 = req_hi_cnt;
    run_and_check("t3", 4, 1'b0);
    check_eq("t3_req_cycles", 32'(req_hi_cnt - rq0), 32'd4);
    check_eq("t3_store_cnt",  32'(st_cnt - st0),     32'd1);
    check_eq("t3_mem5",       32'(dmem[5]),          32'h08);
    check_eq("t3_cycles8",    cycles,                32'd8);

    // Load with 1-cycle ack, acks pulsed in every non-request cycle
    stray_all = 1'b1;
    prog.delete();
    emit(5, 4, 2);
    emit_epilogue();
    load_prog();
    run_and_check("t4", 1, 1'b0);
    stray_all = 1'b0;
    check_eq("t4_r4", 32'(dmem[4]), 32'd8);
    compare_mem("t4");

    // Taken BRZ skips LDI r3
    prog.delete();
    emit(4, 1, 2); emit(1, 1, 1); emit(7, 0, 2); emit(4, 3, 7); emit(7, 7, 7);
    load_prog();
    run_and_check("t2", 1, 1'b0);
    check_eq("t2_cycles8", cycles, 32'd8);

    // Backward branch from pc 0 wraps to 4094, then 4095 wraps to 0
    prog.delete();
    emit(7, 0, 6);
    emit_epilogue();
    load_prog();
    rom[4094] = enc(4, 4, 5);
    rom[4095] = enc(0, 4, 4);
    run_and_check("t5", 2, 1'b0);
    check_eq("t5_r3_untouched", 32'(dmem[3]), 32'd0);
    check_eq("t5_r4_wrap",      32'(dmem[4]), 32'd10);
    check_eq("t5_z",            32'(dmem[7]), 32'd0);
    compare_mem("t5");

    // BRZ +0 with Z set spins in place
    prog.delete();
    emit(1, 1, 1); emit(7, 0, 0);
    load_prog();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("t6_busy", 32'(busy),      32'd1);
    check_eq("t6_done", 32'(done),      32'd0);
    check_eq("t6_pc",   32'(imem_addr), 32'd1);
    async_reset_check("t6_rst");

    // Reset while a store waits for ack
    prog.delete();
    emit(4, 1, 3); emit(6, 1, 1); emit(7, 7, 7);
    load_prog();
    keep3 = dmem[3];
    ack_lat = 100;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    waited = 0;
    while (!dmem_req && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("t7_req_seen", 32'(dmem_req), 32'd1);
    repeat (2) @(negedge clk);
    st0 = st_cnt;
    async_reset_check("t7_rst");
    check_eq("t7_no_store", 32'(st_cnt - st0), 32'd0);
    check_eq("t7_mem3",     32'(dmem[3]),      32'(keep3));
    prog.delete();
    emit_epilogue();
    load_prog();
    run_and_check("t7_rerun", 2, 1'b0);
    compare_mem("t7_rerun");

    // Random programs with forward branches, random latency, stray acks, start pokes
    stray_en = 1'b1;
    for (int unsigned t = 0; t < 8; t++) begin
      prog.delete();
      len = 10 + $urandom_range(0, 14);
      for (int unsigned k = 0; k < len; k++) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1, 2, 3: emit(sel, $urandom_range(0, 7), $urandom_range(0, 7));
          4, 5:       emit(4, $urandom_range(0, 7), $urandom_range(0, 7));
          6:          emit(5, $urandom_range(0, 7), $urandom_range(0, 7));
          7:          emit(6, $urandom_range(0, 7), $urandom_range(0, 7));
          8:          emit(7, $urandom_range(0, 7), $urandom_range(1, 3));
          default:    emit($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
        endcase
      end
      emit_epilogue();
      load_prog();
      run_and_check($sformatf("rnd%0d", t), $urandom_range(1, 5), 1'b1);
      compare_mem($sformatf("rnd%0d", t));
    end
    stray_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
